// File: rtl/param_updown_counter_if.sv
// Handshake/bus bundle for param_updown_counter.
// The master drives the control inputs and the slave (the counter) returns count, tc, ovf.
// Optional Gray output: present when CNT_GRAY_EN is defined.
interface param_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             sat;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             ovf_clr;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
`ifdef CNT_GRAY_EN
   logic [WIDTH-1:0] gray;

   modport master (
      output en, up, sat, load, load_val, ovf_clr,
      input  count, tc, ovf, gray
   );

   modport slave (
      input  en, up, sat, load, load_val, ovf_clr,
      output count, tc, ovf, gray
   );
`else
   modport master (
      output en, up, sat, load, load_val, ovf_clr,
      input  count, tc, ovf
   );

   modport slave (
      input  en, up, sat, load, load_val, ovf_clr,
      output count, tc, ovf
   );
`endif
endinterface

// File: rtl/param_updown_counter.sv
// Synchronous up/down modulo-MODULUS counter.
// It supports parallel load with clamping, wrap or saturate at the limits, a one-cycle
// terminal-count pulse and a sticky overflow flag.
// Optional feature macro CNT_GRAY_EN: when defined, a registered Gray-coded copy of the
// count is driven on bus.gray.
module param_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input logic                   clk,
   input logic                   rst,
   param_updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             tc_reg;
   logic             ovf_reg;
   logic             limit_hit;

   // Next-count and limit-event decode; load beats enable
   always_comb begin
      count_next = count_reg;
      limit_hit  = 1'b0;
      if (bus.load) begin
         count_next = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      end else if (bus.en) begin
         if (bus.up) begin
            if (count_reg == MAX_VAL) begin
               limit_hit  = 1'b1;
               count_next = bus.sat ? count_reg : '0;
            end else begin
               count_next = count_reg + WIDTH'(1);
            end
         end else begin
            if (count_reg == '0) begin
               limit_hit  = 1'b1;
               count_next = bus.sat ? count_reg : MAX_VAL;
            end else begin
               count_next = count_reg - WIDTH'(1);
            end
         end
      end
   end

   // Count, terminal-count pulse and sticky overflow (a set beats a coincident clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
         tc_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         tc_reg    <= limit_hit;
         if (limit_hit) begin
            ovf_reg <= 1'b1;
         end else if (bus.ovf_clr) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   assign bus.count = count_reg;
   assign bus.tc    = tc_reg;
   assign bus.ovf   = ovf_reg;

`ifdef CNT_GRAY_EN
   logic [WIDTH-1:0] gray_reg;

   // Gray code is built from the next count so it lines up with count in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gray_reg <= '0;
      end else begin
         gray_reg <= count_next ^ (count_next >> 1);
      end
   end

   assign bus.gray = gray_reg;
`endif
endmodule
